mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one WIDTH-bit output channel among four requesters.
- Contains the 4:1 data select. Drives select, a one-hot grant and per-requester acks.
- Hands the output to a single downstream consumer over a valid/ready handshake.
- Sits in front of any shared sink that consumes the selected input stream.

---
 rtl/mux4_rr_arbiter_if.sv | 28 ++
 rtl/mux4_rr_arbiter.sv | 101 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four requesters, the round-robin arbiter and one downstream consumer.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mux4_rr_arbiter_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic [3:0]       req;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] in4;
    logic             out_ready;
    logic [1:0]       select;
    logic [3:0]       gnt;
    logic [3:0]       ack;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;

    modport slave (
        input  req, in1, in2, in3, in4, out_ready,
        output select, gnt, ack, out, out_valid, busy
    );

    modport master (
        output req, in1, in2, in3, in4, out_ready,
        input  select, gnt, ack, out, out_valid, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one output channel among four requesters, with a per-grant
// beat limit that forces rotation and a valid/ready handshake to a single consumer.
module mux4_rr_arbiter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux4_rr_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q;
    logic [1:0] select_q;
    logic [3:0] gnt_q;
    logic [3:0] beat_cnt_q;
    logic [1:0] last_q;

    logic [3:0]       req;
    logic             out_valid;
    logic             accept;
    logic             release_grant;
    logic [1:0]       pick;
    logic [WIDTH-1:0] data_sel;

    // Scan last+1 .. last+4; walking backwards lets the earliest hit overwrite later ones.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (mask[idx]) rr_pick = idx;
        end
    endfunction

    assign req = bus.req;

    // Gating with rst_n keeps an ack from escaping in the cycle a reset aborts a grant.
    assign out_valid     = rst_n & gnt_q[select_q] & req[select_q];
    assign accept        = out_valid & bus.out_ready;
    assign release_grant = ~req[select_q] | (accept & (beat_cnt_q == 4'(MAX_BEATS - 1)));
    assign pick          = rr_pick(req, (state_q == StGrant) ? select_q : last_q);

    always_comb begin
        data_sel = '0;
        unique case (select_q)
            2'd0: data_sel = bus.in1;
            2'd1: data_sel = bus.in2;
            2'd2: data_sel = bus.in3;
            2'd3: data_sel = bus.in4;
            default: data_sel = '0;
        endcase
    end

    assign bus.out       = out_valid ? data_sel : '0;
    assign bus.out_valid = out_valid;
    assign bus.ack       = accept ? (4'b0001 << select_q) : 4'b0000;
    assign bus.select    = select_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q == StGrant);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            select_q   <= 2'd0;
            gnt_q      <= 4'b0000;
            beat_cnt_q <= 4'd0;
            last_q     <= 2'd3;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        state_q    <= StGrant;
                        select_q   <= pick;
                        gnt_q      <= 4'b0001 << pick;
                        beat_cnt_q <= 4'd0;
                    end
                end
                StGrant: begin
                    if (release_grant) begin
                        last_q     <= select_q;
                        beat_cnt_q <= 4'd0;
                        // Re-arbitrate in the release edge so ownership changes without a bubble.
                        if (|req) begin
                            select_q <= pick;
                            gnt_q    <= 4'b0001 << pick;
                        end else begin
                            state_q <= StIdle;
                            gnt_q   <= 4'b0000;
                        end
                    end else if (accept) begin
                        beat_cnt_q <= beat_cnt_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one DUT with MAX_BEATS=4 and one with MAX_BEATS=2.
module tb_mux4_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.WIDTH(4)) b ();
    mux4_rr_arbiter_if #(.WIDTH(4)) b2 ();

    mux4_rr_arbiter #(.WIDTH(4), .MAX_BEATS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    mux4_rr_arbiter #(.WIDTH(4), .MAX_BEATS(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b.req = 4'b0; b.in1 = 4'h0; b.in2 = 4'h0; b.in3 = 4'h0; b.in4 = 4'h0; b.out_ready = 1'b0;
        b2.req = 4'b0; b2.in1 = 4'h0; b2.in2 = 4'h0; b2.in3 = 4'h0; b2.in4 = 4'h0;
        b2.out_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (b.select !== 2'd0) $display("FAIL reset_select got %0d want 0", b.select); else n_pass++;
        n_checks++; if (b.gnt !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", b.gnt); else n_pass++;
        n_checks++; if (b.out !== 4'h0) $display("FAIL reset_out got %b want 0000", b.out); else n_pass++;
        n_checks++; if (b.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", b.out_valid); else n_pass++;
        n_checks++; if (b.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", b.busy); else n_pass++;
        n_checks++; if (b.ack !== 4'b0000) $display("FAIL reset_ack got %b want 0000", b.ack); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        b.in1 = 4'b0001; b.req = 4'b0001; b.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (b.gnt !== 4'b0000) $display("FAIL single_pre_gnt got %b want 0000", b.gnt); else n_pass++;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (b.gnt !== 4'b0001) $display("FAIL single_gnt[%0d] got %b want 0001", i, b.gnt); else n_pass++;
            n_checks++; if (b.ack !== 4'b0001) $display("FAIL single_ack[%0d] got %b want 0001", i, b.ack); else n_pass++;
            n_checks++; if (b.out !== 4'b0001) $display("FAIL single_out[%0d] got %b want 0001", i, b.out); else n_pass++;
            tick();
        end
        b.req = 4'b0000;
        @(negedge clk);
        n_checks++; if (b.ack !== 4'b0000) $display("FAIL single_drop_ack got %b want 0000", b.ack); else n_pass++;
        n_checks++; if (b.out_valid !== 1'b0) $display("FAIL single_drop_valid got %b want 0", b.out_valid); else n_pass++;
        n_checks++; if (b.busy !== 1'b1) $display("FAIL single_drop_busy got %b want 1", b.busy); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (b.gnt !== 4'b0000) $display("FAIL single_idle_gnt got %b want 0000", b.gnt); else n_pass++;
        n_checks++; if (b.busy !== 1'b0) $display("FAIL single_idle_busy got %b want 0", b.busy); else n_pass++;
        b.out_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_data [4];
        logic [1:0] owner;
        exp_data[0] = 4'b0001; exp_data[1] = 4'b0011; exp_data[2] = 4'b0111; exp_data[3] = 4'b1111;
        apply_reset();
        b.in1 = 4'b0001; b.in2 = 4'b0011; b.in3 = 4'b0111; b.in4 = 4'b1111;
        b.req = 4'b1111; b.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            owner = 2'((i / 4) % 4);
            @(negedge clk);
            n_checks++; if (b.select !== owner) $display("FAIL rr_select[%0d] got %0d want %0d", i, b.select, owner); else n_pass++;
            n_checks++; if (b.ack !== (4'b0001 << owner)) $display("FAIL rr_ack[%0d] got %b want %b", i, b.ack, 4'b0001 << owner); else n_pass++;
            n_checks++; if (b.out !== exp_data[owner]) $display("FAIL rr_out[%0d] got %b want %b", i, b.out, exp_data[owner]); else n_pass++;
            tick();
        end
        b.req = 4'b0000; b.out_ready = 1'b0;
        tick();
        @(negedge clk);
        n_checks++; if (b.gnt !== 4'b0000) $display("FAIL rr_idle_gnt got %b want 0000", b.gnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        apply_reset();
        b.in3 = 4'b0111; b.req = 4'b0100; b.out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (b.out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b want 1", i, b.out_valid); else n_pass++;
            n_checks++; if (b.out !== 4'b0111) $display("FAIL bp_out[%0d] got %b want 0111", i, b.out); else n_pass++;
            n_checks++; if (b.ack !== 4'b0000) $display("FAIL bp_ack[%0d] got %b want 0000", i, b.ack); else n_pass++;
            n_checks++; if (b.select !== 2'd2) $display("FAIL bp_select[%0d] got %0d want 2", i, b.select); else n_pass++;
            tick();
        end
        b.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (b.ack !== 4'b0100) $display("FAIL bp_release_ack got %b want 0100", b.ack); else n_pass++;
        tick();
        b.req = 4'b0000; b.out_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_sole_rotation();
        apply_reset();
        b2.in4 = 4'b1111; b2.in1 = 4'b0001; b2.req = 4'b1000; b2.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if (b2.ack !== 4'b1000) $display("FAIL sole_ack[%0d] got %b want 1000", i, b2.ack); else n_pass++;
            n_checks++; if (b2.select !== 2'd3) $display("FAIL sole_select[%0d] got %0d want 3", i, b2.select); else n_pass++;
            n_checks++; if (b2.gnt !== 4'b1000) $display("FAIL sole_gnt[%0d] got %b want 1000", i, b2.gnt); else n_pass++;
            tick();
            // A second requester arriving at the start of a grant must wait out both beats.
            if (i == 3) b2.req = 4'b1001;
        end
        @(negedge clk);
        n_checks++; if (b2.select !== 2'd0) $display("FAIL sole_rotate_select got %0d want 0", b2.select); else n_pass++;
        n_checks++; if (b2.ack !== 4'b0001) $display("FAIL sole_rotate_ack got %b want 0001", b2.ack); else n_pass++;
        n_checks++; if (b2.out !== 4'b0001) $display("FAIL sole_rotate_out got %b want 0001", b2.out); else n_pass++;
        b2.req = 4'b0000; b2.out_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        b.in1 = 4'b0001; b.in2 = 4'b0011; b.req = 4'b0010; b.out_ready = 1'b0;
        tick();
        @(negedge clk);
        n_checks++; if (b.select !== 2'd1) $display("FAIL mid_select got %0d want 1", b.select); else n_pass++;
        n_checks++; if (b.out_valid !== 1'b1) $display("FAIL mid_valid got %b want 1", b.out_valid); else n_pass++;
        tick();
        rst_n = 1'b0; b.req = 4'b1111; b.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (b.ack !== 4'b0000) $display("FAIL mid_rst_cycle_ack got %b want 0000", b.ack); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (b.gnt !== 4'b0000) $display("FAIL mid_after_gnt got %b want 0000", b.gnt); else n_pass++;
        n_checks++; if (b.ack !== 4'b0000) $display("FAIL mid_after_ack got %b want 0000", b.ack); else n_pass++;
        n_checks++; if (b.out !== 4'h0) $display("FAIL mid_after_out got %b want 0000", b.out); else n_pass++;
        n_checks++; if (b.busy !== 1'b0) $display("FAIL mid_after_busy got %b want 0", b.busy); else n_pass++;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (b.select !== 2'd0) $display("FAIL mid_regrant_select got %0d want 0", b.select); else n_pass++;
        n_checks++; if (b.gnt !== 4'b0001) $display("FAIL mid_regrant_gnt got %b want 0001", b.gnt); else n_pass++;
        b.req = 4'b0000; b.out_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_sole_rotation();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
